fib_ram_ctrl: RTL and testbench
===============================

FIB_RAM_CTRL -- requirements
Module: fib_ram_ctrl

Interface
REQ-001: Parameter N, default 6, address bus width; sizes RAM depth 2**N.
REQ-002: Parameter M, default 8, data bus width; Fibonacci terms are M-bit unsigned.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  request to fill RAM; sampled on rising clk edge.
REQ-006: count  input  N  number of terms to write; sampled with start.
REQ-007: host_addr  input  N  host read address; used only while idle.
REQ-008: host_rd_data  output  M  host read data; valid only while busy=0.
REQ-009: busy  output  1  high while a fill is in progress.
REQ-010: done  output  1  one-cycle pulse at the end of a fill.
REQ-011: ovf  output  1  sticky flag: a written term was truncated to M bits.
REQ-012: ram_addr  output  N  address to the single-port RAM.
REQ-013: ram_data_in  output  M  write data to the RAM.
REQ-014: ram_we  output  1  RAM write enable; the RAM writes on the rising clk edge.
REQ-015: ram_data_out  input  M  RAM asynchronous read data.

Function
REQ-016: The FSM shall have exactly three states: IDLE, WRITE and FINISH.
REQ-017: IDLE: busy=0, ram_we=0, ram_addr=host_addr, host_rd_data=ram_data_out (combinational, same cycle).
REQ-018: IDLE with start=1 and count>0: latch count into cnt_q, set a=0, b=1, idx=0, clear ovf, and go to WRITE.
REQ-019: IDLE with start=1 and count=0: clear ovf, go to FINISH, perform no writes.
REQ-020: WRITE: busy=1, ram_we=1, ram_addr=idx, ram_data_in=a; all are Moore outputs decoded from state and registers.
REQ-021: Each WRITE cycle: a<=b; b<=(a+b) mod 2**M; idx<=idx+1.
REQ-022: A carry flag shall travel with each of a and b; the flag for a new b is the carry-out of a+b OR either operand's flag.
REQ-023: ovf shall be set in a WRITE cycle only when the flag of the a being written is 1; it shall never be set by a term that is not written.
REQ-024: WRITE with idx==cnt_q-1: go to FINISH after this write.
REQ-025: FINISH: busy=0, ram_we=0, done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-026: Latency: start at edge k gives writes at addresses 0..count-1 on edges k+1..k+count; done is high in the cycle after edge k+count.
REQ-027: A start asserted in WRITE or FINISH shall be ignored; it shall not be queued.
REQ-028: A change on count or host_addr while busy=1 shall have no effect on the fill in progress.
REQ-029: Maximum fill is 2**N-1 terms; idx shall not wrap during a fill.
REQ-030: ovf shall hold its value until the next accepted start.

Reset
REQ-031: rst_n=0 shall force IDLE immediately, without waiting for a clock edge; ram_we=0, busy=0, done=0, ovf=0, and a, b, idx, cnt_q and the carry flags are all cleared.
REQ-032: A reset during WRITE shall abort the fill; RAM words already written stay in the RAM and are not cleared.

Verification
REQ-033: M=8, count=10, start pulse -> addresses 0..9 hold 0,1,1,2,3,5,8,13,21,34; done high in cycle 11 after start; ovf=0; host reads match.
REQ-034: count=14 -> address 13 holds 233 and ovf=0, even though the internal b wrapped (377). Then count=15 -> address 14 holds 121 and ovf=1.
REQ-035: count=0 -> no ram_we pulses; done high in the cycle after start; busy never high.
REQ-036: start held high for the whole of a count=5 fill -> exactly 5 writes and one done; a new fill begins only after IDLE is re-entered.
REQ-037: rst_n low after 3 writes of a count=10 fill -> ram_we=0 and busy=0 with no clock edge; addresses 0..2 hold 0,1,1; the next start refills correctly.
REQ-038: count=63 (N=6) -> 63 writes; address 63 is untouched; idx does not wrap.

Source files
------------

// File: rtl/fib_ram_ctrl.sv
// fib_ram_ctrl: fills an external single-port RAM with the first count Fibonacci terms
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, count_i       fill request and number of terms, sampled in IDLE
//   host_addr_i            host read address, routed to the RAM while idle
//   host_rd_data_o         host read data (RAM read data passed through)
//   busy_o, done_o, ovf_o  fill in progress, end-of-fill pulse, sticky truncation flag
//   ram_addr_o, ram_data_in_o, ram_we_o, ram_data_out_i   single-port RAM interface
module fib_ram_ctrl #(
   parameter int N = 6,
   parameter int M = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [N-1:0] count_i,
   input  logic [N-1:0] host_addr_i,
   output logic [M-1:0] host_rd_data_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         ovf_o,
   output logic [N-1:0] ram_addr_o,
   output logic [M-1:0] ram_data_in_o,
   output logic         ram_we_o,
   input  logic [M-1:0] ram_data_out_i
);
   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_e;
   state_e       state_q, state_d;
   logic [M-1:0] a_q, a_d, b_q, b_d;
   logic         af_q, af_d, bf_q, bf_d;
   logic [N-1:0] idx_q, idx_d, cnt_q, cnt_d;
   logic         ovf_q, ovf_d;
   logic [M:0]   sum;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         af_q    <= 1'b0;
         bf_q    <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         af_q    <= af_d;
         bf_q    <= bf_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      af_d    = af_q;
      bf_d    = bf_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum     = {1'b0, a_q} + {1'b0, b_q};
      case (state_q)
         IDLE: if (start_i) begin
            ovf_d = 1'b0;
            if (count_i != '0) begin
               cnt_d   = count_i;
               a_d     = '0;
               b_d     = M'(1);
               af_d    = 1'b0;
               bf_d    = 1'b0;
               idx_d   = '0;
               state_d = WRITE;
            end else begin
               state_d = FINISH;
            end
         end
         WRITE: begin
            // each flag marks a term whose true value no longer fits in M bits;
            // only the term being written (a) may raise ovf
            a_d   = b_q;
            af_d  = bf_q;
            b_d   = sum[M-1:0];
            bf_d  = sum[M] | af_q | bf_q;
            idx_d = idx_q + N'(1);
            ovf_d = ovf_q | af_q;
            if (idx_q == cnt_q - N'(1)) state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign busy_o         = (state_q == WRITE);
   assign ram_we_o       = (state_q == WRITE);
   assign done_o         = (state_q == FINISH);
   assign ovf_o          = ovf_q;
   assign ram_addr_o     = (state_q == WRITE) ? idx_q : host_addr_i;
   assign ram_data_in_o  = a_q;
   assign host_rd_data_o = ram_data_out_i;
endmodule

// File: tb/tb_fib_ram_ctrl.sv
// tb_fib_ram_ctrl: randomized scoreboard bench for fib_ram_ctrl with a behavioural RAM
module tb_fib_ram_ctrl;
   localparam int N = 6;
   localparam int M = 8;
   localparam int D = 64;
   typedef struct {int addr; int data; int cyc;} wexp_t;
   typedef struct {int ovf; int cyc;} dexp_t;
   logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
   logic [N-1:0] count = '0, host_addr = '0, ram_addr;
   logic [M-1:0] host_rd_data, ram_data_in, ram_data_out;
   logic         busy, done, ovf, ram_we;
   logic [M-1:0] mem [D];
   logic [M-1:0] ref_mem [D];
   int           cyc = 0, n_chk = 0, n_fail = 0;
   bit           exp_ovf = 1'b0;
   wexp_t        wq[$];
   dexp_t        dq[$];

   fib_ram_ctrl #(.N(N), .M(M)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .count_i(count),
      .host_addr_i(host_addr), .host_rd_data_o(host_rd_data),
      .busy_o(busy), .done_o(done), .ovf_o(ovf),
      .ram_addr_o(ram_addr), .ram_data_in_o(ram_data_in),
      .ram_we_o(ram_we), .ram_data_out_i(ram_data_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [M-1:0] init_val(int i);
      return M'((i * 37 + 11) & 255);
   endfunction

   initial begin
      for (int i = 0; i < D; i++) mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (ram_we) mem[ram_addr] <= ram_data_in;
      end
   end
   assign ram_data_out = mem[ram_addr];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      wexp_t e;
      dexp_t d;
      if (rst_n) begin
         if (ram_we) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               e = wq.pop_front();
               chk("wr_addr", ram_addr, e.addr);
               chk("wr_data", ram_data_in, e.data);
               chk("wr_cycle", cyc, e.cyc);
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               d = dq.pop_front();
               chk("done_ovf", ovf, d.ovf);
               chk("done_cycle", cyc, d.cyc);
               chk("done_busy", busy, 0);
            end
         end
      end
   end

   // Issue one fill of n terms; abort_after >= 0 pulls reset after that many writes.
   task automatic fill(input int n, input bit hold, input int abort_after);
      int k, nw;
      longint unsigned a, b, t;
      bit ov;
      wexp_t e;
      dexp_t d;
      @(negedge clk);
      start = 1'b1;
      count = N'(n);
      k = cyc + 1;
      nw = (abort_after >= 0 && abort_after < n) ? abort_after : n;
      a = 0;
      b = 1;
      ov = 1'b0;
      for (int i = 0; i < nw; i++) begin
         e.addr = i;
         e.data = int'(a & 255);
         e.cyc = k + i;
         wq.push_back(e);
         ref_mem[i] = M'(a & 255);
         if (a > 255) ov = 1'b1;
         t = a + b;
         a = b;
         b = t;
      end
      if (nw == n) begin
         d.ovf = int'(ov);
         d.cyc = k + n;
         dq.push_back(d);
         exp_ovf = ov;
      end else begin
         exp_ovf = 1'b0;
      end
      for (int c = 0; c <= n; c++) begin
         if (nw != n && c == nw) begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            start = 1'b0;
            #1;
            chk("abort_we", ram_we, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_ovf", ovf, 0);
            wq.delete();
            dq.delete();
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
         @(negedge clk);
         chk("busy", busy, c < n);
         start = hold ? 1'b1 : 1'($urandom_range(1));
         count = N'($urandom);
         host_addr = N'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      #2;
      chk("writes_outstanding", wq.size(), 0);
      chk("done_outstanding", dq.size(), 0);
   endtask

   task automatic host_check();
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("ovf_hold", ovf, exp_ovf);
      for (int i = 0; i < D; i++) begin
         host_addr = N'(i);
         #1;
         chk("host_read", host_rd_data, ref_mem[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < D; i++) ref_mem[i] = init_val(i);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      host_check();
      fill(10, 1'b0, -1);
      host_check();
      fill(14, 1'b0, -1);
      host_check();
      fill(15, 1'b0, -1);
      host_check();
      fill(0, 1'b0, -1);
      host_check();
      fill(5, 1'b1, -1);
      host_check();
      fill(10, 1'b0, 3);
      host_check();
      fill(10, 1'b0, -1);
      host_check();
      fill(63, 1'b0, -1);
      host_check();
      repeat (4) begin
         fill(int'($urandom_range(63)), 1'($urandom_range(1)), -1);
         host_check();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
